// File: rtl/branch_resolve.sv
// EX-stage branch resolution: turns compare flags plus funct3 into a taken decision,
// checks it against the IF prediction and issues a registered redirect and IF/ID flush.
module branch_resolve #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [2:0]       funct3_i,
  input  logic             rs1_msb_i,
  input  logic             rs2_msb_i,
  input  logic             zero_i,
  input  logic             less_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  output logic             taken_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] cnt_branch_o,
  output logic [CNT_W-1:0] cnt_mispred_o
);

  // Counter only needs to hold FLUSH_LEN-1.
  localparam int unsigned FcW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e           state_q, state_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic             taken_q, taken_d;
  logic             redirect_q, redirect_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;

  logic slt;
  logic legal;
  logic dec;

  // Branch condition decode from the compare flags.
  always_comb begin
    slt   = (rs1_msb_i != rs2_msb_i) ? rs1_msb_i : less_i;
    legal = (funct3_i[2:1] != 2'b01);
    dec   = 1'b0;
    unique case (funct3_i)
      3'b000:  dec = zero_i;
      3'b001:  dec = !zero_i;
      3'b100:  dec = slt;
      3'b101:  dec = !slt;
      3'b110:  dec = less_i;
      3'b111:  dec = !less_i;
      default: dec = 1'b0;
    endcase
  end

  // Next-state: resolve in IDLE, count down the flush window; stall freezes everything.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    taken_d    = taken_q;
    redirect_d = 1'b0;
    illegal_d  = 1'b0;
    rpc_d      = rpc_q;
    cnt_br_d   = cnt_br_q;
    cnt_mp_d   = cnt_mp_q;
    if (!stall_i) begin
      unique case (state_q)
        StIdle: begin
          if (br_valid_i) begin
            if (legal) begin
              taken_d  = dec;
              cnt_br_d = cnt_br_q + CNT_W'(1);
              if (dec != pred_taken_i) begin
                cnt_mp_d   = cnt_mp_q + CNT_W'(1);
                redirect_d = 1'b1;
                rpc_d      = dec ? (pc_i + imm_i) : (pc_i + XLEN'(4));
                state_d    = StFlush;
                fcnt_d     = FcW'(FLUSH_LEN - 1);
              end
            end else begin
              taken_d   = 1'b0;
              illegal_d = 1'b1;
            end
          end
        end
        StFlush: begin
          // Wrong-path branches arriving here are ignored.
          if (fcnt_q == '0) begin
            state_d = StIdle;
          end else begin
            fcnt_d = fcnt_q - FcW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      rpc_q      <= '0;
      cnt_br_q   <= '0;
      cnt_mp_q   <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
      rpc_q      <= rpc_d;
      cnt_br_q   <= cnt_br_d;
      cnt_mp_q   <= cnt_mp_d;
    end
  end

  assign taken_o       = taken_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = rpc_q;
  assign flush_o       = (state_q == StFlush);
  assign illegal_o     = illegal_q;
  assign cnt_branch_o  = cnt_br_q;
  assign cnt_mispred_o = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table plus flush/stall/wrap/reset sequences.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_valid_i;
  logic [2:0]  funct3_i;
  logic        rs1_msb_i;
  logic        rs2_msb_i;
  logic        zero_i;
  logic        less_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic        pred_taken_i;
  logic        taken_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        illegal_o;
  logic [3:0]  cnt_branch_o;
  logic [3:0]  cnt_mispred_o;

  int checks = 0;
  int errors = 0;

  branch_resolve #(
    .XLEN      (32),
    .FLUSH_LEN (2),
    .CNT_W     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .br_valid_i    (br_valid_i),
    .funct3_i      (funct3_i),
    .rs1_msb_i     (rs1_msb_i),
    .rs2_msb_i     (rs2_msb_i),
    .zero_i        (zero_i),
    .less_i        (less_i),
    .pc_i          (pc_i),
    .imm_i         (imm_i),
    .pred_taken_i  (pred_taken_i),
    .taken_o       (taken_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_o       (flush_o),
    .illegal_o     (illegal_o),
    .cnt_branch_o  (cnt_branch_o),
    .cnt_mispred_o (cnt_mispred_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        r1m;
    logic        r2m;
    logic        z;
    logic        lt;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        e_taken;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_ill;
    logic [3:0]  e_cb;
    logic [3:0]  e_cm;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic v, input logic [2:0] f3, input logic r1m, input logic r2m,
                        input logic z, input logic lt, input logic pred,
                        input logic [31:0] pc, input logic [31:0] imm);
    br_valid_i   = v;
    funct3_i     = f3;
    rs1_msb_i    = r1m;
    rs2_msb_i    = r2m;
    zero_i       = z;
    less_i       = lt;
    pred_taken_i = pred;
    pc_i         = pc;
    imm_i        = imm;
  endtask

  initial begin
    int fl_cycles;
    int rd_pulses;
    //          f3      r1m r2m z  lt pred pc            imm           tk rd rpc           il cb cm
    vecs[0]  = '{3'b000, 0, 0, 1, 0, 0, 32'h100,      32'h20,       1, 1, 32'h120,      0, 1, 1};
    vecs[1]  = '{3'b100, 1, 0, 0, 0, 1, 32'h200,      32'h40,       1, 0, 32'h120,      0, 2, 1};
    vecs[2]  = '{3'b111, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h10,       0, 1, 32'h0,        0, 3, 2};
    vecs[3]  = '{3'b001, 0, 0, 0, 0, 1, 32'h300,      32'h8,        1, 0, 32'h0,        0, 4, 2};
    vecs[4]  = '{3'b101, 0, 1, 0, 1, 1, 32'h400,      32'h8,        1, 0, 32'h0,        0, 5, 2};
    vecs[5]  = '{3'b110, 0, 0, 0, 0, 1, 32'h500,      32'hFFFFFFF0, 0, 1, 32'h504,      0, 6, 3};
    vecs[6]  = '{3'b101, 1, 1, 0, 1, 0, 32'h600,      32'h100,      0, 0, 32'h504,      0, 7, 3};
    vecs[7]  = '{3'b100, 0, 0, 0, 1, 0, 32'h700,      32'hFFFFFF00, 1, 1, 32'h600,      0, 8, 4};
    vecs[8]  = '{3'b010, 0, 0, 1, 0, 0, 32'h780,      32'h4,        0, 0, 32'h600,      1, 8, 4};
    vecs[9]  = '{3'b011, 0, 0, 0, 0, 1, 32'h790,      32'h4,        0, 0, 32'h600,      1, 8, 4};
    vecs[10] = '{3'b000, 0, 0, 0, 0, 0, 32'h800,      32'h40,       0, 0, 32'h600,      0, 9, 4};

    rst_n   = 1'b0;
    stall_i = 1'b0;
    set_br(0, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    chk("rst_taken", {31'b0, taken_o}, 32'h0);
    chk("rst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("rst_rpc", redirect_pc_o, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_cnt_br", {28'b0, cnt_branch_o}, 32'h0);
    chk("rst_cnt_mp", {28'b0, cnt_mispred_o}, 32'h0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      set_br(1, vecs[i].f3, vecs[i].r1m, vecs[i].r2m, vecs[i].z, vecs[i].lt, vecs[i].pred,
             vecs[i].pc, vecs[i].imm);
      step();
      chk($sformatf("v%0d_taken", i), {31'b0, taken_o}, {31'b0, vecs[i].e_taken});
      chk($sformatf("v%0d_redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].e_redir});
      chk($sformatf("v%0d_rpc", i), redirect_pc_o, vecs[i].e_rpc);
      chk($sformatf("v%0d_illegal", i), {31'b0, illegal_o}, {31'b0, vecs[i].e_ill});
      chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].e_redir});
      chk($sformatf("v%0d_cnt_br", i), {28'b0, cnt_branch_o}, {28'b0, vecs[i].e_cb});
      chk($sformatf("v%0d_cnt_mp", i), {28'b0, cnt_mispred_o}, {28'b0, vecs[i].e_cm});
      br_valid_i = 1'b0;
      step();
      chk($sformatf("v%0d_pulse_end", i), {30'b0, redirect_o, illegal_o}, 32'h0);
      step();
      step();
      chk($sformatf("v%0d_flush_end", i), {31'b0, flush_o}, 32'h0);
    end

    // Mispredict followed by wrong-path BNE inside the flush window.
    set_br(1, 3'b000, 0, 0, 1, 0, 0, 32'h1000, 32'h4);
    step();
    chk("wp_redirect", {31'b0, redirect_o}, 32'h1);
    chk("wp_rpc", redirect_pc_o, 32'h1004);
    set_br(1, 3'b001, 0, 0, 0, 0, 0, 32'h1100, 32'h40);
    step();
    chk("wp_flush1", {31'b0, flush_o}, 32'h1);
    chk("wp_redirect1", {31'b0, redirect_o}, 32'h0);
    chk("wp_cnt_br1", {28'b0, cnt_branch_o}, 32'd10);
    step();
    chk("wp_flush2", {31'b0, flush_o}, 32'h0);
    chk("wp_cnt_br2", {28'b0, cnt_branch_o}, 32'd10);
    chk("wp_cnt_mp2", {28'b0, cnt_mispred_o}, 32'd5);
    chk("wp_rpc2", redirect_pc_o, 32'h1004);
    br_valid_i = 1'b0;
    step();

    // Stall in IDLE: a would-be mispredict is not resolved.
    stall_i = 1'b1;
    set_br(1, 3'b000, 0, 0, 1, 0, 0, 32'h1800, 32'h4);
    step();
    chk("si_redirect", {31'b0, redirect_o}, 32'h0);
    chk("si_flush", {31'b0, flush_o}, 32'h0);
    chk("si_cnt_br", {28'b0, cnt_branch_o}, 32'd10);
    chk("si_taken_hold", {31'b0, taken_o}, 32'h1);
    stall_i    = 1'b0;
    br_valid_i = 1'b0;
    step();

    // Stall for 3 cycles mid-flush stretches flush to FLUSH_LEN+3 with one redirect.
    fl_cycles = 0;
    rd_pulses = 0;
    set_br(1, 3'b000, 0, 0, 1, 0, 0, 32'h2000, 32'h8);
    step();
    fl_cycles += int'(flush_o);
    rd_pulses += int'(redirect_o);
    br_valid_i = 1'b0;
    stall_i    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      fl_cycles += int'(flush_o);
      rd_pulses += int'(redirect_o);
    end
    stall_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      fl_cycles += int'(flush_o);
      rd_pulses += int'(redirect_o);
    end
    chk("st_flush_cycles", fl_cycles, 32'd5);
    chk("st_redirects", rd_pulses, 32'd1);
    chk("st_rpc", redirect_pc_o, 32'h2008);
    chk("st_cnt_mp", {28'b0, cnt_mispred_o}, 32'd6);

    // Five back-to-back correct branches take the 4-bit counter from 11 through 0.
    for (int k = 0; k < 5; k++) begin
      set_br(1, 3'b000, 0, 0, 1, 0, 1, 32'h3000 + 32'(k * 4), 32'h10);
      step();
      chk($sformatf("wr_cnt_br%0d", k), {28'b0, cnt_branch_o}, 32'((12 + k) % 16));
      chk($sformatf("wr_redirect%0d", k), {31'b0, redirect_o}, 32'h0);
    end
    chk("wr_cnt_mp", {28'b0, cnt_mispred_o}, 32'd6);
    br_valid_i = 1'b0;
    step();

    // Reset in the middle of a flush clears everything on the next cycle.
    set_br(1, 3'b001, 0, 0, 0, 0, 0, 32'h3000, 32'h10);
    step();
    chk("rf_flush_on", {31'b0, flush_o}, 32'h1);
    chk("rf_rpc", redirect_pc_o, 32'h3010);
    rst_n      = 1'b0;
    br_valid_i = 1'b0;
    step();
    chk("rf_flush", {31'b0, flush_o}, 32'h0);
    chk("rf_redirect", {31'b0, redirect_o}, 32'h0);
    chk("rf_taken", {31'b0, taken_o}, 32'h0);
    chk("rf_rpc0", redirect_pc_o, 32'h0);
    chk("rf_cnts", {24'b0, cnt_branch_o, cnt_mispred_o}, 32'h0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
